// File: rtl/membus_arbiter.sv
// Single-port memory bus arbiter: host register bus plus two layer renderers, one access per cycle.
// Optional starvation guard for the renderers is compiled in with `define MEMBUS_ARB_STARVE_GUARD_EN.
module membus_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic [17:0] host_addr,
    input  logic [7:0]  host_wrdata,
    input  logic        host_write,
    input  logic        host_strobe,
    output logic        host_ack,

    input  logic [17:0] l1_addr,
    input  logic        l1_strobe,
    output logic        l1_ack,

    input  logic [17:0] l2_addr,
    input  logic        l2_strobe,
    output logic        l2_ack,

    output logic [17:0] mem_addr,
    output logic [31:0] mem_wrdata,
    output logic [3:0]  mem_bytesel,
    output logic        mem_write,
    output logic        mem_strobe,
    output logic [1:0]  rd_sel
);

    // Handshake: a request is a strobe level; the cycle it wins arbitration it drives the
    // memory bus, and exactly one cycle later its ack pulses (read data valid) for one cycle.
    // The grant is committed once made; a strobe still high after its ack is a new request.

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_HOST = 2'd1,
        OWN_L1   = 2'd2,
        OWN_L2   = 2'd3
    } owner_e;

    typedef enum logic {
        RR_L1 = 1'b0,
        RR_L2 = 1'b1
    } rr_e;

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_limit_check
        $error("membus_arbiter: STARVE_LIMIT must lie in 1..15");
    end

    owner_e grant;
    owner_e rd_sel_q, rd_sel_d;
    rr_e    rr_q, rr_d;
    logic   host_ack_q, host_ack_d;
    logic   l1_ack_q, l1_ack_d;
    logic   l2_ack_q, l2_ack_d;
    logic   ren_pending;
    logic   ren_pick_l2;
    logic   guard_force;

    assign ren_pending = l1_strobe | l2_strobe;

    // Renderer choice when no host is involved: the round-robin pointer only matters on a tie.
    always_comb begin
        ren_pick_l2 = l2_strobe;
        if (l1_strobe && l2_strobe) begin
            ren_pick_l2 = (rr_q == RR_L2);
        end
    end

`ifdef MEMBUS_ARB_STARVE_GUARD_EN
    localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);

    logic [3:0] starve_q, starve_d;

    assign guard_force = ren_pending && (starve_q == LIMIT_C);

    // Counts host wins while a renderer is waiting; any renderer win or no waiting renderer clears it.
    always_comb begin
        starve_d = starve_q;
        if (grant == OWN_L1 || grant == OWN_L2 || !ren_pending) begin
            starve_d = 4'd0;
        end else if (grant == OWN_HOST && starve_q != 4'hF) begin
            starve_d = starve_q + 4'd1;
        end
    end
`else
    assign guard_force = 1'b0;
`endif

    // Reset gates the grant so the bus stays idle while reset is held.
    always_comb begin
        grant = OWN_NONE;
        if (!reset) begin
            if (host_strobe && !guard_force) begin
                grant = OWN_HOST;
            end else if (ren_pending) begin
                grant = ren_pick_l2 ? OWN_L2 : OWN_L1;
            end
        end
    end

    always_comb begin
        mem_addr   = 18'd0;
        mem_strobe = 1'b0;
        mem_write  = 1'b0;
        case (grant)
            OWN_HOST: begin
                mem_addr   = host_addr;
                mem_strobe = 1'b1;
                mem_write  = host_write;
            end
            OWN_L1: begin
                mem_addr   = l1_addr;
                mem_strobe = 1'b1;
            end
            OWN_L2: begin
                mem_addr   = l2_addr;
                mem_strobe = 1'b1;
            end
            default: begin
                mem_addr   = 18'd0;
                mem_strobe = 1'b0;
            end
        endcase
    end

    assign mem_bytesel = 4'b0001 << mem_addr[1:0];
    assign mem_wrdata  = {4{host_wrdata}};

    always_comb begin
        rr_d       = rr_q;
        host_ack_d = (grant == OWN_HOST);
        l1_ack_d   = (grant == OWN_L1);
        l2_ack_d   = (grant == OWN_L2);
        rd_sel_d   = grant;
        if (grant == OWN_L1) begin
            rr_d = RR_L2;
        end else if (grant == OWN_L2) begin
            rr_d = RR_L1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_q       <= RR_L1;
            host_ack_q <= 1'b0;
            l1_ack_q   <= 1'b0;
            l2_ack_q   <= 1'b0;
            rd_sel_q   <= OWN_NONE;
`ifdef MEMBUS_ARB_STARVE_GUARD_EN
            starve_q   <= 4'd0;
`endif
        end else begin
            rr_q       <= rr_d;
            host_ack_q <= host_ack_d;
            l1_ack_q   <= l1_ack_d;
            l2_ack_q   <= l2_ack_d;
            rd_sel_q   <= rd_sel_d;
`ifdef MEMBUS_ARB_STARVE_GUARD_EN
            starve_q   <= starve_d;
`endif
        end
    end

    assign host_ack = host_ack_q;
    assign l1_ack   = l1_ack_q;
    assign l2_ack   = l2_ack_q;
    assign rd_sel   = rd_sel_q;

endmodule

// File: tb/tb_membus_arbiter.sv
// Bench for membus_arbiter: directed scenarios plus random traffic against a grant-order reference model.
// Starvation expectations follow whether MEMBUS_ARB_STARVE_GUARD_EN is defined for the build.
module tb_membus_arbiter;

    localparam int LIMIT = 4;
`ifdef MEMBUS_ARB_STARVE_GUARD_EN
    localparam bit GUARD_ON = 1'b1;
`else
    localparam bit GUARD_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [17:0] host_addr;
    logic [7:0]  host_wrdata;
    logic        host_write;
    logic        host_strobe;
    logic        host_ack;
    logic [17:0] l1_addr;
    logic        l1_strobe;
    logic        l1_ack;
    logic [17:0] l2_addr;
    logic        l2_strobe;
    logic        l2_ack;
    logic [17:0] mem_addr;
    logic [31:0] mem_wrdata;
    logic [3:0]  mem_bytesel;
    logic        mem_write;
    logic        mem_strobe;
    logic [1:0]  rd_sel;

    membus_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .host_addr(host_addr), .host_wrdata(host_wrdata), .host_write(host_write),
        .host_strobe(host_strobe), .host_ack(host_ack),
        .l1_addr(l1_addr), .l1_strobe(l1_strobe), .l1_ack(l1_ack),
        .l2_addr(l2_addr), .l2_strobe(l2_strobe), .l2_ack(l2_ack),
        .mem_addr(mem_addr), .mem_wrdata(mem_wrdata), .mem_bytesel(mem_bytesel),
        .mem_write(mem_write), .mem_strobe(mem_strobe), .rd_sel(rd_sel)
    );

    always #20 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Scoreboard: owner (0 none, 1 host, 2 l1, 3 l2) granted each cycle, acked the next.
    logic [1:0] exp_q[$];

    // Reference model state: which renderer wins the next tie, and how many host wins in a row
    // have happened while some renderer was asking.
    bit m_next_l2;
    int m_streak;

    task automatic model_reset();
        m_next_l2 = 1'b0;
        m_streak  = 0;
        exp_q.delete();
    endtask

    function automatic logic [1:0] model_grant(bit h, bit s1, bit s2);
        bit force_ren;
        force_ren = GUARD_ON && (s1 || s2) && (m_streak == LIMIT);
        if (h && !force_ren) return 2'd1;
        if (s1 && s2) return m_next_l2 ? 2'd3 : 2'd2;
        if (s1) return 2'd2;
        if (s2) return 2'd3;
        return 2'd0;
    endfunction

    task automatic model_update(logic [1:0] g, bit s1, bit s2);
        if (g == 2'd2) m_next_l2 = 1'b1;
        if (g == 2'd3) m_next_l2 = 1'b0;
        if (g >= 2'd2 || !(s1 || s2)) m_streak = 0;
        else if (g == 2'd1) m_streak = m_streak + 1;
    endtask

    // One bus cycle: drive at the falling edge, check registered and combinational outputs
    // shortly after, then advance the model across the coming rising edge.
    task automatic step(input bit h, input bit hw, input logic [17:0] ha, input logic [7:0] hd,
                        input bit s1, input logic [17:0] a1, input bit s2, input logic [17:0] a2);
        logic [1:0]  prev;
        logic [1:0]  g;
        logic [2:0]  exp_acks;
        logic [17:0] ea;
        logic [3:0]  ebs;
        logic [31:0] ewd;
        @(negedge clk);
        host_strobe = h; host_write = hw; host_addr = ha; host_wrdata = hd;
        l1_strobe = s1; l1_addr = a1; l2_strobe = s2; l2_addr = a2;
        #1;
        prev = (exp_q.size() > 0) ? exp_q.pop_front() : 2'd0;
        exp_acks = {prev == 2'd1, prev == 2'd2, prev == 2'd3};
        n_tests++;
        if ({host_ack, l1_ack, l2_ack} !== exp_acks) begin
            n_fail++;
            $display("FAIL acks: got %b expected %b at %0t", {host_ack, l1_ack, l2_ack}, exp_acks, $time);
        end
        n_tests++;
        if (rd_sel !== prev) begin
            n_fail++;
            $display("FAIL rd_sel: got %0d expected %0d at %0t", rd_sel, prev, $time);
        end
        g   = model_grant(h, s1, s2);
        ea  = (g == 2'd1) ? ha : (g == 2'd2) ? a1 : (g == 2'd3) ? a2 : 18'd0;
        ebs = 4'(1 << (ea % 4));
        ewd = 32'(hd) * 32'h0101_0101;
        n_tests++;
        if (mem_strobe !== (g != 2'd0)) begin
            n_fail++;
            $display("FAIL mem_strobe: got %b expected %b at %0t", mem_strobe, g != 2'd0, $time);
        end
        n_tests++;
        if (mem_addr !== ea) begin
            n_fail++;
            $display("FAIL mem_addr: got %05h expected %05h (owner %0d) at %0t", mem_addr, ea, g, $time);
        end
        n_tests++;
        if (mem_write !== (g == 2'd1 && hw)) begin
            n_fail++;
            $display("FAIL mem_write: got %b expected %b at %0t", mem_write, g == 2'd1 && hw, $time);
        end
        n_tests++;
        if (mem_bytesel !== ebs) begin
            n_fail++;
            $display("FAIL mem_bytesel: got %b expected %b at %0t", mem_bytesel, ebs, $time);
        end
        n_tests++;
        if (mem_wrdata !== ewd) begin
            n_fail++;
            $display("FAIL mem_wrdata: got %08h expected %08h at %0t", mem_wrdata, ewd, $time);
        end
        exp_q.push_back(g);
        model_update(g, s1, s2);
    endtask

    task automatic idle();
        step(0, 0, 18'd0, 8'd0, 0, 18'd0, 0, 18'd0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        host_strobe = 1'b1; host_write = 1'b1; host_addr = 18'h2AAAA; host_wrdata = 8'h77;
        l1_strobe = 1'b1; l1_addr = 18'h00123; l2_strobe = 1'b1; l2_addr = 18'h00456;
        @(negedge clk); #1;
        n_tests++;
        if ({mem_strobe, mem_write, mem_addr} !== 20'd0) begin
            n_fail++;
            $display("FAIL reset_bus: got strobe=%b write=%b addr=%05h expected all 0", mem_strobe, mem_write, mem_addr);
        end
        n_tests++;
        if ({host_ack, l1_ack, l2_ack, rd_sel} !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_regs: got acks=%b rd_sel=%0d expected 0", {host_ack, l1_ack, l2_ack}, rd_sel);
        end
        @(negedge clk);
        host_strobe = 1'b0; l1_strobe = 1'b0; l2_strobe = 1'b0; host_write = 1'b0;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_host_read();
        step(1, 0, 18'h00005, 8'h3C, 0, 18'd0, 0, 18'd0);
        n_tests++;
        if (mem_bytesel !== 4'b0010) begin
            n_fail++;
            $display("FAIL host_read_bytesel: got %b expected 0010", mem_bytesel);
        end
        idle();
        n_tests++;
        if (host_ack !== 1'b1 || rd_sel !== 2'd1) begin
            n_fail++;
            $display("FAIL host_read_ack: got ack=%b rd_sel=%0d expected ack=1 rd_sel=1", host_ack, rd_sel);
        end
    endtask

    task automatic test_round_robin();
        logic [17:0] order [4];
        order[0] = 18'h00100; order[1] = 18'h00200; order[2] = 18'h00100; order[3] = 18'h00200;
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 18'd0, 8'd0, 1, 18'h00100, 1, 18'h00200);
            n_tests++;
            if (mem_addr !== order[i]) begin
                n_fail++;
                $display("FAIL rr_order[%0d]: got %05h expected %05h", i, mem_addr, order[i]);
            end
        end
        idle();
        idle();
    endtask

    task automatic test_host_vs_l1();
        step(1, 0, 18'h01000, 8'h11, 1, 18'h02004, 0, 18'd0);
        n_tests++;
        if (mem_addr !== 18'h01000) begin
            n_fail++;
            $display("FAIL host_first: got %05h expected 01000", mem_addr);
        end
        step(0, 0, 18'h01000, 8'h11, 1, 18'h02004, 0, 18'd0);
        n_tests++;
        if (mem_addr !== 18'h02004 || host_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL l1_second: got addr=%05h host_ack=%b expected 02004/1", mem_addr, host_ack);
        end
        idle();
        n_tests++;
        if (l1_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL l1_ack_latency: got %b expected 1", l1_ack);
        end
        idle();
    endtask

    task automatic test_host_write();
        step(1, 1, 18'h1FFFF, 8'hA5, 0, 18'd0, 0, 18'd0);
        n_tests++;
        if (mem_wrdata !== 32'hA5A5A5A5 || mem_bytesel !== 4'b1000 || mem_write !== 1'b1) begin
            n_fail++;
            $display("FAIL host_write: got wd=%08h bs=%b we=%b expected A5A5A5A5/1000/1",
                     mem_wrdata, mem_bytesel, mem_write);
        end
        idle();
        n_tests++;
        if (mem_write !== 1'b0 || host_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL host_write_after: got we=%b ack=%b expected 0/1", mem_write, host_ack);
        end
    endtask

    task automatic test_starvation();
        int l1_wins;
        int exp_wins;
        l1_wins  = 0;
        exp_wins = GUARD_ON ? 20 / (LIMIT + 1) : 0;
        idle();
        for (int i = 0; i < 20; i++) begin
            step(1, 0, 18'h00040, 8'h00, 1, 18'h00080, 0, 18'd0);
            if (mem_addr == 18'h00080) l1_wins++;
        end
        n_tests++;
        if (l1_wins !== exp_wins) begin
            n_fail++;
            $display("FAIL starvation_count: got %0d l1 grants expected %0d", l1_wins, exp_wins);
        end
        idle();
        idle();
    endtask

    task automatic test_reset_mid();
        step(0, 0, 18'd0, 8'd0, 0, 18'd0, 1, 18'h00300);
        @(posedge clk); #1;
        reset = 1'b1;
        l2_strobe = 1'b0;
        @(negedge clk); #1;
        n_tests++;
        if (l2_ack !== 1'b0 || rd_sel !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_mid_l2: got l2_ack=%b rd_sel=%0d expected 0/0", l2_ack, rd_sel);
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        step(0, 0, 18'd0, 8'd0, 1, 18'h00310, 1, 18'h00320);
        n_tests++;
        if (mem_addr !== 18'h00310) begin
            n_fail++;
            $display("FAIL reset_mid_rr: got %05h expected 00310", mem_addr);
        end
        // Second round: leave the pointer on l2, then reset before the ack lands.
        step(0, 0, 18'd0, 8'd0, 1, 18'h00330, 0, 18'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        l1_strobe = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        step(0, 0, 18'd0, 8'd0, 1, 18'h00340, 1, 18'h00350);
        n_tests++;
        if (mem_addr !== 18'h00340) begin
            n_fail++;
            $display("FAIL reset_rr_pointer: got %05h expected 00340", mem_addr);
        end
        idle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) < 35, $urandom_range(0, 1) == 1,
                 18'($urandom_range(0, 18'h3FFFF)), 8'($urandom_range(0, 255)),
                 $urandom_range(0, 99) < 60, 18'($urandom_range(0, 18'h3FFFF)),
                 $urandom_range(0, 99) < 60, 18'($urandom_range(0, 18'h3FFFF)));
        end
        idle();
        idle();
    endtask

    initial begin
        reset = 1'b1;
        host_strobe = 1'b0; host_write = 1'b0; host_addr = 18'd0; host_wrdata = 8'd0;
        l1_strobe = 1'b0; l1_addr = 18'd0; l2_strobe = 1'b0; l2_addr = 18'd0;
        model_reset();
        test_reset();
        test_host_read();
        test_round_robin();
        test_host_vs_l1();
        test_host_write();
        test_starvation();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
